// File: rtl/dfp_burst_adapter.sv
// dfp_burst_adapter: cache-side line port to narrow burst memory.
// Takes whole-line reads/writes from the cache and turns each into a fixed
// BURST_BEATS-beat burst, assembling or disassembling the line on the way.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a line request; write wins over read
// RD_REQ   | burst read command on bmem, held until bmem_ready
// RD_DATA  | collecting read beats tagged with the latched line address
// WR_BURST | presenting write beats, advancing only when bmem_ready
// RESP     | one-cycle dfp_resp; request re-sampled the cycle after
module dfp_burst_adapter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64,
  parameter int BURST_BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata,
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << OFFSET) - 64'd1);

  // The line must split into a whole number of beats with nothing left over.
  if (BURST_BEATS * BEAT_WIDTH != LINE_WIDTH) begin : g_bad_geometry
    $error("dfp_burst_adapter: BURST_BEATS*BEAT_WIDTH must equal LINE_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_BURST,
    RESP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [LINE_WIDTH-1:0]   rd_line;
  logic [LINE_WIDTH-1:0]   wr_line;

  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic                    beat_hit;
  logic [LINE_WIDTH-1:0]   line_next;
  logic [LINE_WIDTH-1:0]   wr_shift;

  // Request address with the in-line byte offset stripped.
  assign aligned_addr = dfp_addr & ~OFFSET_MASK;

  // A read beat counts only while collecting and only for our own line;
  // bmem_addr still holds the latched line address during RD_DATA.
  assign beat_hit = (state == RD_DATA) && bmem_rvalid && (bmem_raddr == bmem_addr);

  // Assembly buffer with the incoming beat merged into slice cnt.
  always_comb begin
    line_next = rd_line;
    line_next[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH] = bmem_rdata;
  end

  // Write line shifted down one beat so the next beat sits in the low slice.
  assign wr_shift = wr_line >> BEAT_WIDTH;

  // Burst sequencer with all bmem/dfp outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_line    <= '0;
      wr_line    <= '0;
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      dfp_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dfp_write) begin
            bmem_addr  <= aligned_addr;
            wr_line    <= dfp_wdata;
            bmem_wdata <= dfp_wdata[BEAT_WIDTH-1:0];
            bmem_write <= 1'b1;
            cnt        <= '0;
            state      <= WR_BURST;
          end else if (dfp_read) begin
            bmem_addr <= aligned_addr;
            bmem_read <= 1'b1;
            cnt       <= '0;
            state     <= RD_REQ;
          end
        end

        RD_REQ: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state     <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (beat_hit) begin
            rd_line <= line_next;
            if (cnt == LAST_BEAT) begin
              dfp_rdata <= line_next;
              dfp_resp  <= 1'b1;
              cnt       <= '0;
              state     <= RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        WR_BURST: begin
          if (bmem_ready) begin
            if (cnt == LAST_BEAT) begin
              bmem_write <= 1'b0;
              bmem_wdata <= '0;
              dfp_resp   <= 1'b1;
              cnt        <= '0;
              state      <= RESP;
            end else begin
              cnt        <= cnt + 1'b1;
              wr_line    <= wr_shift;
              bmem_wdata <= wr_shift[BEAT_WIDTH-1:0];
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfp_burst_adapter.sv
// Bench for dfp_burst_adapter: directed scenarios plus random transactions,
// with a behavioural memory and line-level expectations held in the bench.
module tb_dfp_burst_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int n_cmp;
  int n_err;
  logic [255:0] last_rline;

  dfp_burst_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_resp"}, dfp_resp, 1'b0);
    check({tag, "_rdata"}, dfp_rdata, 256'd0);
    check({tag, "_bread"}, bmem_read, 1'b0);
    check({tag, "_bwrite"}, bmem_write, 1'b0);
    check({tag, "_baddr"}, bmem_addr, 32'd0);
    check({tag, "_bwdata"}, bmem_wdata, 64'd0);
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One cache transaction against a behavioural burst memory.
  // mode 0: always ready, beats back to back; 1: random ready and gaps;
  // 2: ready low only on cycle 2. abort_beats>0 returns right after that
  // many read beats have been taken, leaving the request asserted.
  task automatic txn(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                     input logic [255:0] wline, input logic [255:0] rline,
                     input int mode, input bit noise, input int exp_lat,
                     input int abort_beats);
    logic [31:0] al;
    logic [63:0] wq[$];
    bit rd_acc, real_beat, drop_wr, drop_rd, done;
    int rbeat, resp_n, resp_exp, cyc, quiet;
    al = addr - (addr % 32);
    if (do_wr) for (int i = 0; i < 4; i++) wq.push_back(wline[64*i +: 64]);
    resp_exp = int'(do_rd) + int'(do_wr);
    rd_acc = 0; drop_wr = 0; drop_rd = 0; done = 0;
    rbeat = 0; resp_n = 0; cyc = 0; quiet = 0;
    dfp_addr = addr; dfp_read = do_rd; dfp_write = do_wr; dfp_wdata = wline;
    while (!done) begin
      bmem_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : !(mode == 2 && cyc == 2);
      bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0; real_beat = 0;
      if (rd_acc && rbeat < 4 && (mode != 1 || $urandom_range(0, 1) == 1)) begin
        bmem_rvalid = 1'b1; bmem_raddr = al; bmem_rdata = rline[64*rbeat +: 64];
        real_beat = 1;
      end else if (noise && $urandom_range(0, 2) == 0) begin
        bmem_rvalid = 1'b1;
        bmem_raddr = (!rd_acc && $urandom_range(0, 1) == 1) ? al : (al ^ 32'h0000_00C0);
        bmem_rdata = {$urandom, $urandom};
      end

      if (bmem_write) begin
        check("wr_beat_expected", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          check("wr_data", bmem_wdata, wq[0]);
          check("wr_addr", bmem_addr, al);
          if (bmem_ready) void'(wq.pop_front());
        end
      end
      if (bmem_read) begin
        check("rd_cmd_expected", do_rd && !rd_acc && !drop_rd && resp_n == int'(do_wr), 1'b1);
        check("rd_addr", bmem_addr, al);
        if (bmem_ready) rd_acc = 1;
      end
      if (dfp_resp) begin
        resp_n++;
        if (do_wr && resp_n == 1) begin
          check("wr_resp_beats_left", wq.size(), 0);
          check("rdata_hold_wr", dfp_rdata, last_rline);
          drop_wr = 1;
        end else begin
          check("rd_resp_beats", rbeat, 4);
          check("rd_line", dfp_rdata, rline);
          last_rline = rline;
          drop_rd = 1;
        end
        if (resp_n == 1 && exp_lat >= 0) check("resp_latency", cyc, exp_lat);
        check("resp_count_ok", resp_n <= resp_exp, 1'b1);
      end else begin
        check("rdata_hold", dfp_rdata, last_rline);
      end
      if (real_beat) rbeat++;

      @(posedge clk);
      #1;
      cyc++;
      if (abort_beats > 0 && rbeat >= abort_beats) return;
      if (drop_wr) dfp_write = 1'b0;
      if (drop_rd) dfp_read = 1'b0;
      if (resp_n >= resp_exp) quiet++;
      if (quiet >= 4) done = 1;
      if (cyc > 300) begin
        check("txn_timeout_resps", resp_n, resp_exp);
        done = 1;
      end
    end
    dfp_read = 1'b0; dfp_write = 1'b0; bmem_rvalid = 1'b0;
  endtask

  initial begin
    logic [255:0] l1, l2;
    int typ;
    n_cmp = 0; n_err = 0;
    last_rline = '0;
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Read at 0x1234, back-to-back beats, resp at cycle 6.
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    txn(1, 0, 32'h0000_1234, '0, l1, 0, 0, 6, 0);

    // Write at 0x2000 with ready low on cycle 2: A, B, B, C, D, resp cycle 6.
    l2 = {64'hD, 64'hC, 64'hB, 64'hA};
    txn(0, 1, 32'h0000_2000, l2, '0, 2, 0, 6, 0);

    // Read and write together: write first (resp at 5), then the read.
    txn(1, 1, 32'h0000_0040, rnd_line(), rnd_line(), 0, 0, 5, 0);

    // Read 0x40 with stray beats for 0x80 and stray beats outside RD_DATA.
    txn(1, 0, 32'h0000_0040, '0, rnd_line(), 0, 1, 6, 0);

    // Reset after two read beats, stray beats afterwards, then a fresh read.
    txn(1, 0, 32'h0000_0300, '0, rnd_line(), 0, 0, -1, 2);
    rst = 1'b1;
    dfp_read = 1'b0;
    bmem_rvalid = 1'b0;
    @(negedge clk);
    check_quiet("mid_reset");
    last_rline = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0300; bmem_rdata = {$urandom, $urandom};
      bmem_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_no_cmd", bmem_read, 1'b0);
      check("post_reset_no_resp", dfp_resp, 1'b0);
    end
    bmem_rvalid = 1'b0;
    txn(1, 0, 32'h0000_0300, '0, rnd_line(), 0, 0, 6, 0);

    // Random traffic with random ready, gaps and stray beats.
    for (int t = 0; t < 20; t++) begin
      typ = $urandom_range(0, 2);
      txn(typ != 1, typ != 0, $urandom, rnd_line(), rnd_line(), 1,
          $urandom_range(0, 1) == 1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dfp_burst_adapter.md
Name: dfp_burst_adapter

Overview:
- Memory-side responder for the cache downward-facing port (dfp).
- Accepts whole-line read and write requests from the cache, translates each into a fixed-length burst on a narrow burst-memory (bmem) interface, and returns a single-cycle dfp_resp.
- Sits between the cache and the main-memory model/controller; owns line assembly and disassembly.

Parameters:
- ADDR_WIDTH, 32, byte address width on both ports.
- LINE_WIDTH, 256, cache line width in bits (dfp_rdata/dfp_wdata).
- BEAT_WIDTH, 64, bmem data width per beat.
- BURST_BEATS, 4, beats per line; elaboration error unless BURST_BEATS*BEAT_WIDTH == LINE_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- dfp_addr  in  ADDR_WIDTH  line address from cache; offset bits ignored.
- dfp_read  in  1  line read request, held until dfp_resp.
- dfp_write  in  1  line write request, held until dfp_resp.
- dfp_wdata  in  LINE_WIDTH  write line data.
- dfp_rdata  out  LINE_WIDTH  assembled read line, valid when dfp_resp=1.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  ADDR_WIDTH  line-aligned burst address.
- bmem_read  out  1  burst read command.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_WIDTH  current write beat.
- bmem_ready  in  1  memory accepts command/beat this cycle.
- bmem_raddr  in  ADDR_WIDTH  address tag of returning read beats.
- bmem_rdata  in  BEAT_WIDTH  read beat data.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset: state IDLE; dfp_resp=0, dfp_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0; beat counter=0.
- States: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP.
- IDLE: when dfp_write=1, latch aligned address {dfp_addr[ADDR_WIDTH-1:OFFSET], 0} (OFFSET=log2(LINE_WIDTH/8)) and dfp_wdata, then go to WR_BURST. Otherwise, when dfp_read=1, latch the address and go to RD_REQ.
- Priority: if dfp_read and dfp_write are both asserted, the write is served first (writeback before refill).
- RD_REQ: bmem_read=1 and bmem_addr=latched address. Hold until bmem_ready=1, then go to RD_DATA.
- RD_DATA: on each bmem_rvalid=1 with bmem_raddr==latched address, store bmem_rdata into line slice [BEAT_WIDTH*k +: BEAT_WIDTH], where k is the beat count (beat 0 = least significant). After the BURST_BEATS-th beat, go to RESP.
  - Beats with a mismatched raddr are ignored.
  - Gaps between beats are allowed.
- WR_BURST: bmem_write=1, bmem_addr=latched address, bmem_wdata=slice k of the latched line.
  - k advances only when bmem_ready=1; the beat is held while bmem_ready=0.
  - After the last beat is accepted, go to RESP.
- RESP: dfp_resp=1 for exactly one cycle, then IDLE. A new request is sampled no earlier than the cycle after RESP, so a held request is never double-served.
- dfp_rdata updates only on read completion and holds between reads. A write does not alter it.
- bmem_rvalid outside RD_DATA is ignored.
- Minimum latency with bmem_ready=1 and back-to-back beats:
  - Read: request seen at cycle 0, bmem_read at cycle 1, beats at cycles 2..5, dfp_resp at cycle 6.
  - Write: beats at cycles 1..4, dfp_resp at cycle 5.
- Reset asserted mid-burst: immediate return to IDLE with all outputs deasserted and the counter cleared. Stray beats arriving after reset are ignored.
- Counter width is clog2(BURST_BEATS); the count wraps to 0 on entry to RD_REQ/WR_BURST.

Test Plan:
- Read 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with no gaps -> bmem_addr=0x0000_1220; dfp_resp at cycle 6; dfp_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write 0x0000_2000, line = {64'hD, 64'hC, 64'hB, 64'hA}, bmem_ready low on cycle 2 -> beats A, B, B (held), C, D; dfp_resp one cycle after D is accepted.
- dfp_read=dfp_write=1 at 0x40 -> write burst completes and dfp_resp pulses; read burst starts after re-sample; two dfp_resp pulses total.
- rvalid with raddr=0x80 while 0x40 is outstanding, plus a rvalid during IDLE -> both ignored; the line is assembled only from 0x40 beats.
- rst asserted after 2 read beats -> all outputs 0 next edge, state IDLE; a fresh read completes with correct data.
- Request held high through the dfp_resp cycle -> exactly one burst is issued per request.
